// File: rtl/serial_io_controller.sv
// Memory-mapped serial port controller: CPU bus registers (data 0x8, stat 0xc), TX/RX byte FIFOs,
// and the start/busy handshake sequencer toward a byte-level UART PHY.
`ifndef IO_LB
`define IO_LB 4'b0011
`endif
`ifndef IO_SB
`define IO_SB 4'b0111
`endif

module serial_io_controller #(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        irq
);

    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [TAW:0] TX_ONE = 1;
    localparam logic [RAW:0] RX_ONE = 1;

    typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} tx_state_e;

    logic rd_data_req, wr_data_req, rd_stat_req;

    logic [7:0]   tx_mem_q [TX_DEPTH];
    logic [7:0]   tx_mem_d [TX_DEPTH];
    logic [TAW:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [7:0]   rx_mem_q [RX_DEPTH];
    logic [7:0]   rx_mem_d [RX_DEPTH];
    logic [RAW:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;

    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push, tx_pop, rx_push, rx_pop;

    tx_state_e state_q, state_d;
    logic      hi_cnt_q, hi_cnt_d;
    logic      tx_drop_q, tx_drop_d, rx_ovr_q, rx_ovr_d, irq_q, irq_d;

    logic unused_bus;
    assign unused_bus = ^{addr[31:4], wdata[31:8]};

    assign rd_data_req = (mode == `IO_LB) && (addr[3:0] == 4'h8);
    assign wr_data_req = (mode == `IO_SB) && (addr[3:0] == 4'h8);
    assign rd_stat_req = (mode == `IO_LB) && (addr[3:0] == 4'hc);

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[TAW] != tx_rptr_q[TAW]) &&
                      (tx_wptr_q[TAW-1:0] == tx_rptr_q[TAW-1:0]);
    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[RAW] != rx_rptr_q[RAW]) &&
                      (rx_wptr_q[RAW-1:0] == rx_rptr_q[RAW-1:0]);

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign tx_pop  = (state_q == START) && !tx_empty;
    assign tx_push = wr_data_req && (!tx_full || tx_pop);
    assign rx_pop  = rd_data_req && !rx_empty;
    assign rx_push = rx_valid && (!rx_full || rx_pop);

    always_comb begin
        tx_mem_d = tx_mem_q;
        rx_mem_d = rx_mem_q;
        if (tx_push) tx_mem_d[tx_wptr_q[TAW-1:0]] = wdata[7:0];
        if (rx_push) rx_mem_d[rx_wptr_q[RAW-1:0]] = rx_data;
        tx_wptr_d = tx_push ? tx_wptr_q + TX_ONE : tx_wptr_q;
        tx_rptr_d = tx_pop  ? tx_rptr_q + TX_ONE : tx_rptr_q;
        rx_wptr_d = rx_push ? rx_wptr_q + RX_ONE : rx_wptr_q;
        rx_rptr_d = rx_pop  ? rx_rptr_q + RX_ONE : rx_rptr_q;
    end

    // A fresh error in the clearing cycle must survive the clear.
    always_comb begin
        tx_drop_d = tx_drop_q;
        rx_ovr_d  = rx_ovr_q;
        if (rd_stat_req) begin
            tx_drop_d = 1'b0;
            rx_ovr_d  = 1'b0;
        end
        if (wr_data_req && tx_full && !tx_pop) tx_drop_d = 1'b1;
        if (rx_valid && rx_full && !rx_pop)    rx_ovr_d  = 1'b1;
        irq_d = (rx_wptr_d != rx_rptr_d) || tx_drop_d || rx_ovr_d;
    end

    always_comb begin
        rdata = 32'h0;
        if (rd_data_req && !rx_empty) begin
            rdata = {24'h0, rx_mem_q[rx_rptr_q[RAW-1:0]]};
        end else if (rd_stat_req) begin
            rdata = {28'h0, tx_drop_q, rx_ovr_q, !rx_empty, !tx_full};
        end
    end

    // hi_cnt gives WAIT_HI two cycles to see busy before assuming the PHY took the byte silently.
    always_comb begin
        state_d  = state_q;
        hi_cnt_d = hi_cnt_q;
        tx_start = 1'b0;
        tx_data  = 8'h0;
        case (state_q)
            IDLE: begin
                if (!tx_empty && !tx_busy) state_d = START;
            end
            START: begin
                tx_start = 1'b1;
                tx_data  = tx_mem_q[tx_rptr_q[TAW-1:0]];
                hi_cnt_d = 1'b0;
                state_d  = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy)       state_d = WAIT_LO;
                else if (hi_cnt_q) state_d = IDLE;
                else               hi_cnt_d = 1'b1;
            end
            WAIT_LO: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            state_q   <= IDLE;
            hi_cnt_q  <= 1'b0;
            tx_drop_q <= 1'b0;
            rx_ovr_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            state_q   <= state_d;
            hi_cnt_q  <= hi_cnt_d;
            tx_drop_q <= tx_drop_d;
            rx_ovr_q  <= rx_ovr_d;
            irq_q     <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        tx_mem_q <= tx_mem_d;
        rx_mem_q <= rx_mem_d;
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_serial_io_controller.sv
// Bench for serial_io_controller: queue-based reference model compared every cycle, a reactive PHY,
// directed scenarios with literal expectations, then a randomized phase.
`ifndef IO_LB
`define IO_LB 4'b0011
`endif
`ifndef IO_SB
`define IO_SB 4'b0111
`endif

module tb_serial_io_controller;

    localparam int TXD = 4;
    localparam int RXD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mode;
    logic [31:0] addr, wdata, rdata;
    logic [7:0]  tx_data, rx_data;
    logic        tx_start, rx_valid, irq;
    logic        tx_busy = 1'b0;

    always #5 clk = ~clk;

    serial_io_controller #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk(clk), .rst(rst), .mode(mode), .addr(addr), .wdata(wdata), .rdata(rdata),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // PHY: on a start pulse, hold busy for a fixed or random number of cycles (0 = never busy).
    bit phy_stuck = 1'b0;
    bit phy_fixed = 1'b0;
    int busy_left = 0;
    always @(posedge clk) begin
        #1;
        if (phy_stuck) begin
            tx_busy = 1'b1;
        end else begin
            if (tx_start === 1'b1) busy_left = phy_fixed ? 10 : int'($urandom_range(0, 6));
            if (busy_left > 0) begin
                tx_busy = 1'b1;
                busy_left--;
            end else begin
                tx_busy = 1'b0;
            end
        end
    end

    // Reference model: FIFOs as queues, sticky flags as bits.
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] pulse_log[$];
    bit m_tx_drop = 0, m_rx_ovr = 0, m_irq = 0;
    bit prev_busy = 0;
    int since_pulse = 100;
    int stall = 0;
    int pulse_cnt = 0;
    bit rdd, wrd, rds, newtd, newro;
    logic [31:0] exp_r;

    always @(negedge clk) begin
        rdd = (mode == `IO_LB) && (addr[3:0] == 4'h8);
        wrd = (mode == `IO_SB) && (addr[3:0] == 4'h8);
        rds = (mode == `IO_LB) && (addr[3:0] == 4'hc);
        exp_r = 32'h0;
        if (rdd && rxq.size() > 0) exp_r = {24'h0, rxq[0]};
        else if (rds) exp_r = {28'h0, m_tx_drop, m_rx_ovr, rxq.size() != 0, txq.size() < TXD};
        chk("rdata", rdata, exp_r);
        chk("irq", {31'h0, irq}, {31'h0, m_irq});

        if (txq.size() == 0) chk("tx_start_when_empty", {31'h0, tx_start}, 32'h0);
        if (tx_start === 1'b1) begin
            pulse_cnt++;
            pulse_log.push_back(tx_data);
            if (txq.size() > 0) chk("tx_data", {24'h0, tx_data}, {24'h0, txq[0]});
            chk("tx_start_gap_ge4", {31'h0, since_pulse >= 4}, 32'h1);
            chk("tx_start_after_busy_low", {31'h0, prev_busy}, 32'h0);
        end else begin
            chk("tx_data_idle", {24'h0, tx_data}, 32'h0);
        end

        if (!rst && txq.size() > 0) begin
            if (!tx_busy && tx_start !== 1'b1) stall++;
            else stall = 0;
            chk("tx_progress", {31'h0, stall < 5}, 32'h1);
            if (stall >= 5) stall = 0;
        end else begin
            stall = 0;
        end

        prev_busy = tx_busy;
        if (tx_start === 1'b1) since_pulse = 1;
        else if (since_pulse < 100) since_pulse++;

        if (rst) begin
            txq.delete();
            rxq.delete();
            m_tx_drop = 0;
            m_rx_ovr = 0;
            m_irq = 0;
            since_pulse = 100;
        end else begin
            newtd = 0;
            newro = 0;
            if (tx_start === 1'b1 && txq.size() > 0) void'(txq.pop_front());
            if (wrd) begin
                if (txq.size() < TXD) txq.push_back(wdata[7:0]);
                else newtd = 1;
            end
            if (rdd && rxq.size() > 0) void'(rxq.pop_front());
            if (rx_valid) begin
                if (rxq.size() < RXD) rxq.push_back(rx_data);
                else newro = 1;
            end
            if (rds) begin
                m_tx_drop = 0;
                m_rx_ovr = 0;
            end
            if (newtd) m_tx_drop = 1;
            if (newro) m_rx_ovr = 1;
            m_irq = (rxq.size() != 0) || m_tx_drop || m_rx_ovr;
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        mode     = 4'h0;
        addr     = $urandom;
        wdata    = $urandom;
        rx_valid = 1'b0;
        rx_data  = $urandom;
    endtask

    task automatic bus(input logic [3:0] m, input logic [3:0] a, input logic [7:0] wd,
                       input logic rv, input logic [7:0] rd, input bit do_chk,
                       input logic [31:0] exp, input string nm);
        logic [31:0] r;
        r        = $urandom;
        mode     = m;
        addr     = {r[31:4], a};
        wdata    = {r[27:4], wd};
        rx_valid = rv;
        rx_data  = rd;
        @(negedge clk);
        if (do_chk) chk(nm, rdata, exp);
        go();
        set_idle();
    endtask

    task automatic peek_irq(input logic exp, input string nm);
        @(negedge clk);
        chk(nm, {31'h0, irq}, {31'h0, exp});
        go();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        go();
        rst = 1'b0;
    endtask

    int base, base2;
    logic [31:0] rr;

    initial begin
        rst = 1'b1;
        set_idle();
        go();
        go();
        rst = 1'b0;

        // reset state
        bus(`IO_LB, 4'hc, 8'h0, 1'b0, 8'h0, 1'b1, 32'h1, "t1_stat_after_reset");
        bus(`IO_LB, 4'h8, 8'h0, 1'b0, 8'h0, 1'b1, 32'h0, "t1_data_after_reset");
        peek_irq(1'b0, "t1_irq_after_reset");

        // two back-to-back writes, PHY busy 10 cycles per byte
        phy_fixed = 1'b1;
        base = pulse_cnt;
        bus(`IO_SB, 4'h8, 8'h41, 1'b0, 8'h0, 1'b0, 32'h0, "");
        bus(`IO_SB, 4'h8, 8'h42, 1'b0, 8'h0, 1'b0, 32'h0, "");
        repeat (60) go();
        chk("t2_pulse_count", pulse_cnt - base, 2);
        if (pulse_log.size() >= base + 2) begin
            chk("t2_first_byte", {24'h0, pulse_log[base]}, 32'h41);
            chk("t2_second_byte", {24'h0, pulse_log[base + 1]}, 32'h42);
        end

        // TX overflow with PHY stuck busy
        reset_pulse();
        phy_stuck = 1'b1;
        go();
        go();
        for (int i = 0; i < 5; i++) bus(`IO_SB, 4'h8, 8'hA0 + 8'(i), 1'b0, 8'h0, 1'b0, 32'h0, "");
        bus(`IO_LB, 4'hc, 8'h0, 1'b0, 8'h0, 1'b1, 32'h8, "t3_stat_full_drop");
        bus(`IO_LB, 4'hc, 8'h0, 1'b0, 8'h0, 1'b1, 32'h0, "t3_stat_drop_cleared");
        phy_stuck = 1'b0;
        reset_pulse();
        go();

        // single RX byte
        bus(4'h0, 4'h0, 8'h0, 1'b1, 8'h55, 1'b0, 32'h0, "");
        bus(`IO_LB, 4'hc, 8'h0, 1'b0, 8'h0, 1'b1, 32'h3, "t4_stat_rx_ready");
        peek_irq(1'b1, "t4_irq_rx_ready");
        bus(`IO_LB, 4'h8, 8'h0, 1'b0, 8'h0, 1'b1, 32'h55, "t4_read_byte");
        bus(`IO_LB, 4'hc, 8'h0, 1'b0, 8'h0, 1'b1, 32'h1, "t4_stat_after_read");
        peek_irq(1'b0, "t4_irq_after_read");

        // RX overrun, then push+pop on full RX
        for (int i = 0; i < 4; i++) bus(4'h0, 4'h0, 8'h0, 1'b1, 8'h11 + 8'(i), 1'b0, 32'h0, "");
        bus(4'h0, 4'h0, 8'h0, 1'b1, 8'h99, 1'b0, 32'h0, "");
        bus(`IO_LB, 4'hc, 8'h0, 1'b0, 8'h0, 1'b1, 32'h7, "t5_stat_overrun");
        bus(`IO_LB, 4'h8, 8'h0, 1'b1, 8'h99, 1'b1, 32'h11, "t5_read_with_push");
        bus(`IO_LB, 4'hc, 8'h0, 1'b0, 8'h0, 1'b1, 32'h3, "t5_stat_no_overrun");
        bus(`IO_LB, 4'h8, 8'h0, 1'b0, 8'h0, 1'b1, 32'h12, "t5_read_2");
        bus(`IO_LB, 4'h8, 8'h0, 1'b0, 8'h0, 1'b1, 32'h13, "t5_read_3");
        bus(`IO_LB, 4'h8, 8'h0, 1'b0, 8'h0, 1'b1, 32'h14, "t5_read_4");
        bus(`IO_LB, 4'h8, 8'h0, 1'b0, 8'h0, 1'b1, 32'h99, "t5_read_last");
        bus(`IO_LB, 4'hc, 8'h0, 1'b0, 8'h0, 1'b1, 32'h1, "t5_stat_empty");

        // reset during a transmission with bytes still queued
        reset_pulse();
        go();
        base = pulse_cnt;
        bus(`IO_SB, 4'h8, 8'h61, 1'b0, 8'h0, 1'b0, 32'h0, "");
        bus(`IO_SB, 4'h8, 8'h62, 1'b0, 8'h0, 1'b0, 32'h0, "");
        bus(`IO_SB, 4'h8, 8'h63, 1'b0, 8'h0, 1'b0, 32'h0, "");
        for (int i = 0; i < 20 && pulse_cnt == base; i++) go();
        chk("t6_first_pulse", pulse_cnt - base, 1);
        repeat (4) go();
        reset_pulse();
        bus(`IO_LB, 4'hc, 8'h0, 1'b0, 8'h0, 1'b1, 32'h1, "t6_stat_after_reset");
        base2 = pulse_cnt;
        repeat (40) go();
        chk("t6_no_more_pulses", pulse_cnt - base2, 0);

        // randomized traffic
        phy_fixed = 1'b0;
        reset_pulse();
        for (int i = 0; i < 1500; i++) begin
            rr = $urandom_range(0, 99);
            if (rr < 30)      mode = `IO_SB;
            else if (rr < 60) mode = `IO_LB;
            else              mode = 4'($urandom);
            rr = $urandom_range(0, 99);
            addr = $urandom;
            if (rr < 50)      addr[3:0] = 4'h8;
            else if (rr < 85) addr[3:0] = 4'hc;
            wdata    = $urandom;
            rx_valid = ($urandom_range(0, 99) < 30);
            rx_data  = $urandom;
            rst      = ($urandom_range(0, 199) == 0);
            go();
        end
        rst = 1'b0;
        set_idle();
        repeat (30) go();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
